hw2_accum: RTL and testbench

Downstream consumer of the 2-stage (a±b)*c datapath.
- Takes the unsigned 16-bit product stream d with a valid/ready handshake.
- Accumulates N consecutive products per block and presents each block sum on a held output handshake.
- The in_valid fed by the integration level is the upstream input-valid delayed 2 cycles, matching the upstream pipeline latency.

---
 rtl/hw2_accum.sv | 226 ++++++++++++++++++++++
 tb/tb_hw2_accum.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/hw2_accum.sv
// hw2_accum: block accumulator for the unsigned (a+/-b)*c product stream.
// Sums N consecutive accepted products and presents each block sum on a
// handshake that is held until the downstream takes it.
// Build option: define ACC_SAT_EN to saturate the accumulator and the
// presented sum to all-ones once a block overflows. Without it, sums wrap
// modulo 2^AW. In both builds ovf reports the block overflow.

module hw2_accum #(
   parameter int DW = 16,
   parameter int N  = 4,
   parameter int AW = 18
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          in_valid,
   input  logic [DW-1:0] in_d,
   output logic          in_ready,
   output logic          out_valid,
   output logic [AW-1:0] out_sum,
   output logic          ovf,
   input  logic          out_ready,
   output logic          busy
);

   // Sample counter only has to reach N-1.
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ACCUM = 2'b01,
      HOLD  = 2'b10
   } state_t;

   state_t          state_r;
   logic [AW-1:0]   acc_r;
   logic [CW-1:0]   cnt_r;
   logic            sticky_r;
   logic            out_valid_r;
   logic [AW-1:0]   out_sum_r;
   logic            ovf_r;

   logic            in_beat_s;
   logic            last_s;
   logic [AW:0]     sum_s;
   logic            blk_ovf_s;
   logic [AW-1:0]   acc_nxt_s;

   // One extra bit so the carry-out of the add is visible.
   function automatic logic [AW:0] add_wide(input logic [AW-1:0] a,
                                            input logic [DW-1:0] b);
      add_wide = {1'b0, a} + (AW+1)'(b);
   endfunction

   // Value written back into the accumulator after an add.
   function automatic logic [AW-1:0] acc_update(input logic [AW:0] wide,
                                                input logic        blk_ovf);
`ifdef ACC_SAT_EN
      if (blk_ovf) begin
         acc_update = {AW{1'b1}};
      end else begin
         acc_update = wide[AW-1:0];
      end
`else
      acc_update = wide[AW-1:0];
      if (blk_ovf) begin
         acc_update = wide[AW-1:0];
      end else begin
         acc_update = wide[AW-1:0];
      end
`endif
   endfunction

   assign in_ready  = (state_r != HOLD);
   assign busy      = (state_r == ACCUM);
   assign out_valid = out_valid_r;
   assign out_sum   = out_sum_r;
   assign ovf       = ovf_r;

   // Beat qualification and the running sum for the current input.
   always_comb begin
      in_beat_s = 1'b0;
      last_s    = 1'b0;
      sum_s     = {(AW+1){1'b0}};
      blk_ovf_s = 1'b0;
      acc_nxt_s = {AW{1'b0}};
      if (state_r != HOLD) begin
         in_beat_s = in_valid;
      end else begin
         in_beat_s = 1'b0;
      end
      if (cnt_r == CNT_LAST) begin
         last_s = 1'b1;
      end else begin
         last_s = 1'b0;
      end
      sum_s     = add_wide(acc_r, in_d);
      blk_ovf_s = sticky_r | sum_s[AW];
      acc_nxt_s = acc_update(sum_s, blk_ovf_s);
   end

   // Block FSM: accumulator, sample count, sticky overflow and held result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= IDLE;
         acc_r       <= {AW{1'b0}};
         cnt_r       <= {CW{1'b0}};
         sticky_r    <= 1'b0;
         out_valid_r <= 1'b0;
         out_sum_r   <= {AW{1'b0}};
         ovf_r       <= 1'b0;
      end else if (clear) begin
         state_r     <= IDLE;
         acc_r       <= {AW{1'b0}};
         cnt_r       <= {CW{1'b0}};
         sticky_r    <= 1'b0;
         out_valid_r <= 1'b0;
         out_sum_r   <= {AW{1'b0}};
         ovf_r       <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_beat_s) begin
                  // First sample of a block cannot overflow: DW < AW.
                  acc_r    <= AW'(in_d);
                  cnt_r    <= CNT_ONE;
                  sticky_r <= 1'b0;
                  state_r  <= ACCUM;
               end
            end
            ACCUM: begin
               if (in_beat_s) begin
                  if (last_s) begin
                     out_sum_r   <= acc_nxt_s;
                     out_valid_r <= 1'b1;
                     ovf_r       <= blk_ovf_s;
                     acc_r       <= {AW{1'b0}};
                     cnt_r       <= {CW{1'b0}};
                     sticky_r    <= 1'b0;
                     state_r     <= HOLD;
                  end else begin
                     acc_r    <= acc_nxt_s;
                     cnt_r    <= cnt_r + CNT_ONE;
                     sticky_r <= blk_ovf_s;
                  end
               end
            end
            HOLD: begin
               // Input is not ready here, so in_valid is ignored.
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  state_r     <= IDLE;
               end
            end
            default: begin
               // Unreachable encoding: fall back to a clean idle block.
               state_r     <= IDLE;
               acc_r       <= {AW{1'b0}};
               cnt_r       <= {CW{1'b0}};
               sticky_r    <= 1'b0;
               out_valid_r <= 1'b0;
               out_sum_r   <= {AW{1'b0}};
               ovf_r       <= 1'b0;
            end
         endcase
      end
   end

   hw2_accum_chk #(
      .AW (AW),
      .CW (CW),
      .N  (N)
   ) u_chk (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_sum   (out_sum),
      .ovf       (ovf),
      .out_ready (out_ready),
      .busy      (busy),
      .cnt       (cnt_r)
   );

endmodule

// hw2_accum_chk: protocol and state invariants of hw2_accum.
module hw2_accum_chk #(
   parameter int AW = 18,
   parameter int CW = 2,
   parameter int N  = 4
) (
   input logic          clk,
   input logic          reset,
   input logic          clear,
   input logic          in_ready,
   input logic          out_valid,
   input logic [AW-1:0] out_sum,
   input logic          ovf,
   input logic          out_ready,
   input logic          busy,
   input logic [CW-1:0] cnt
);

   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   // A presented block stays frozen until the downstream takes it.
   a_hold_stable: assert property (@(posedge clk) disable iff (!reset)
      (out_valid && !out_ready && !clear) |=> (out_valid && $stable(out_sum) && $stable(ovf)));

   // Input side is ready exactly when no result is being presented.
   a_ready_excl: assert property (@(posedge clk) disable iff (!reset)
      in_ready == !out_valid);

   // Accumulating and presenting are mutually exclusive.
   a_busy_excl: assert property (@(posedge clk) disable iff (!reset)
      !(busy && out_valid));

   // Sample count never passes the last sample index.
   a_cnt_range: assert property (@(posedge clk) disable iff (!reset)
      cnt <= CNT_LAST);

endmodule

// File: tb/tb_hw2_accum.sv
// tb_hw2_accum: directed and randomized checks of hw2_accum, default build
// (AW=18) and a narrow instance (AW=17) that can overflow with N=4.

module tb_hw2_accum;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        clear;
   logic        in_valid;
   logic [15:0] in_d;
   logic        out_ready;

   logic        in_ready, out_valid, ovf, busy;
   logic [17:0] out_sum;
   logic        in_ready_b, out_valid_b, ovf_b, busy_b;
   logic [16:0] out_sum_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   hw2_accum #(.DW(16), .N(N), .AW(18)) u_dut (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_d(in_d),
      .in_ready(in_ready), .out_valid(out_valid), .out_sum(out_sum), .ovf(ovf),
      .out_ready(out_ready), .busy(busy)
   );

   hw2_accum #(.DW(16), .N(N), .AW(17)) u_dut17 (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_d(in_d),
      .in_ready(in_ready_b), .out_valid(out_valid_b), .out_sum(out_sum_b), .ovf(ovf_b),
      .out_ready(out_ready), .busy(busy_b)
   );

   // Reference: block sum from the true (unbounded) total of its samples.
   function automatic logic [63:0] exp_sum(input logic [63:0] total, input int aw);
      logic [63:0] lim;
      lim = 64'd1 << aw;
      if (total < lim) return total;
`ifdef ACC_SAT_EN
      return lim - 64'd1;
`else
      return total % lim;
`endif
   endfunction

   task automatic step(input logic v, input logic [15:0] d, input logic r, input logic c);
      in_valid  = v;
      in_d      = d;
      out_ready = r;
      clear     = c;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_d = 16'h0000; out_ready = 1'b0;
      #2;
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
         checks++; if (out_sum !== 18'h00000) begin errors++; $display("FAIL rst_out_sum: got %h want 00000", out_sum); end
         checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", ovf); end
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
         checks++; if (out_valid_b !== 1'b0) begin errors++; $display("FAIL rst_out_valid17: got %b want 0", out_valid_b); end
      end
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 16'($urandom), 1'b1, 1'b0);
         checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL post_rst_idle: busy=%b in_ready=%b out_valid=%b want 0 1 0", busy, in_ready, out_valid);
         end
      end
   endtask

   task automatic test_basic();
      step(1'b1, 16'h0010, 1'b1, 1'b0);
      step(1'b1, 16'h0020, 1'b1, 1'b0);
      step(1'b1, 16'h0030, 1'b1, 1'b0);
      checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_mid: busy=%b out_valid=%b want 1 0", busy, out_valid); end
      step(1'b1, 16'h0040, 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", out_valid); end
      checks++; if (out_sum !== 18'h000A0) begin errors++; $display("FAIL basic_sum: got %h want 000a0", out_sum); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", ovf); end
      checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_hold: in_ready=%b busy=%b want 0 0", in_ready, busy); end
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_drop: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
   endtask

   task automatic test_backpressure();
      step(1'b1, 16'h0010, 1'b0, 1'b0);
      step(1'b1, 16'h0020, 1'b0, 1'b0);
      step(1'b1, 16'h0030, 1'b0, 1'b0);
      step(1'b1, 16'h0040, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 18'h000A0) begin
            errors++; $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b sum=%h want 1 0 000a0", i, out_valid, in_ready, out_sum);
         end
         step(1'b1, 16'h1234, 1'b0, 1'b0);
      end
      step(1'b1, 16'h1234, 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
      for (int i = 0; i < 4; i++) step(1'b1, 16'h0001, 1'b0, 1'b0);
      checks++; if (out_valid !== 1'b1 || out_sum !== 18'h00004) begin errors++; $display("FAIL bp_next_sum: valid=%b sum=%h want 1 00004", out_valid, out_sum); end
      step(1'b0, 16'h0000, 1'b1, 1'b0);
   endtask

   task automatic test_bubbles();
      step(1'b1, 16'h0000, 1'b1, 1'b0);
      step(1'b0, 16'hAAAA, 1'b1, 1'b0);
      step(1'b1, 16'hFFFF, 1'b1, 1'b0);
      step(1'b0, 16'h5555, 1'b1, 1'b0);
      step(1'b0, 16'h5555, 1'b1, 1'b0);
      checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bub_gap: busy=%b out_valid=%b want 1 0", busy, out_valid); end
      step(1'b1, 16'h0000, 1'b1, 1'b0);
      step(1'b1, 16'h0001, 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b1 || out_sum !== 18'h10000 || ovf !== 1'b0) begin
         errors++; $display("FAIL bub_sum: valid=%b sum=%h ovf=%b want 1 10000 0", out_valid, out_sum, ovf);
      end
      checks++; if (out_sum_b !== 17'h10000 || ovf_b !== 1'b0) begin errors++; $display("FAIL bub_sum17: sum=%h ovf=%b want 10000 0", out_sum_b, ovf_b); end
      step(1'b0, 16'h0000, 1'b1, 1'b0);
   endtask

   task automatic test_overflow();
      logic [16:0] want17;
`ifdef ACC_SAT_EN
      want17 = 17'h1FFFF;
`else
      want17 = 17'h1FFFC;
`endif
      for (int i = 0; i < 4; i++) step(1'b1, 16'hFFFF, 1'b0, 1'b0);
      checks++; if (out_valid_b !== 1'b1 || out_sum_b !== want17 || ovf_b !== 1'b1) begin
         errors++; $display("FAIL ovf17: valid=%b sum=%h ovf=%b want 1 %h 1", out_valid_b, out_sum_b, ovf_b, want17);
      end
      checks++; if (out_sum !== 18'h3FFFC || ovf !== 1'b0) begin errors++; $display("FAIL ovf18: sum=%h ovf=%b want 3fffc 0", out_sum, ovf); end
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      step(1'b1, 16'h0001, 1'b0, 1'b0);
      step(1'b1, 16'h0002, 1'b0, 1'b0);
      step(1'b1, 16'h0003, 1'b0, 1'b0);
      step(1'b1, 16'h0004, 1'b0, 1'b0);
      checks++; if (out_sum_b !== 17'h0000A || ovf_b !== 1'b0) begin errors++; $display("FAIL ovf_after17: sum=%h ovf=%b want 0000a 0", out_sum_b, ovf_b); end
      checks++; if (out_sum !== 18'h0000A || ovf !== 1'b0) begin errors++; $display("FAIL ovf_after18: sum=%h ovf=%b want 0000a 0", out_sum, ovf); end
      step(1'b0, 16'h0000, 1'b1, 1'b0);
   endtask

   task automatic test_abort();
      step(1'b1, 16'h0005, 1'b1, 1'b0);
      step(1'b1, 16'h0006, 1'b1, 1'b0);
      step(1'b1, 16'h0007, 1'b1, 1'b1);
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL clr_state: busy=%b out_valid=%b in_ready=%b want 0 0 1", busy, out_valid, in_ready);
      end
      for (int i = 0; i < 4; i++) step(1'b1, 16'h0001, 1'b0, 1'b0);
      checks++; if (out_valid !== 1'b1 || out_sum !== 18'h00004) begin errors++; $display("FAIL clr_next_sum: valid=%b sum=%h want 1 00004", out_valid, out_sum); end
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      step(1'b1, 16'h0005, 1'b1, 1'b0);
      step(1'b1, 16'h0006, 1'b1, 1'b0);
      reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL arst_async: busy=%b out_valid=%b want 0 0", busy, out_valid); end
      step(1'b1, 16'h0007, 1'b1, 1'b0);
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL arst_state: busy=%b out_valid=%b in_ready=%b want 0 0 1", busy, out_valid, in_ready);
      end
      reset = 1'b1;
      for (int i = 0; i < 4; i++) step(1'b1, 16'h0001, 1'b0, 1'b0);
      checks++; if (out_valid !== 1'b1 || out_sum !== 18'h00004) begin errors++; $display("FAIL arst_next_sum: valid=%b sum=%h want 1 00004", out_valid, out_sum); end
      step(1'b0, 16'h0000, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      logic        v, r, c;
      logic [15:0] d;
      logic        m_hold;
      int          m_n;
      logic [63:0] m_total, e18, e17;
      logic        o18, o17;
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      m_hold = 1'b0; m_n = 0; m_total = 64'd0;
      e18 = 64'd0; e17 = 64'd0; o18 = 1'b0; o17 = 1'b0;
      for (int i = 0; i < 400; i++) begin
         v = ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 2) != 0);
         c = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 5) == 0) d = 16'hFFFF;
         else if ($urandom_range(0, 5) == 0) d = 16'h0000;
         else d = 16'($urandom);
         if (c) begin
            m_hold = 1'b0; m_n = 0; m_total = 64'd0;
         end else if (m_hold) begin
            if (r) m_hold = 1'b0;
         end else if (v) begin
            m_total = m_total + 64'(d);
            m_n++;
            if (m_n == N) begin
               e18 = exp_sum(m_total, 18);
               e17 = exp_sum(m_total, 17);
               o18 = (m_total >= (64'd1 << 18));
               o17 = (m_total >= (64'd1 << 17));
               m_hold = 1'b1; m_n = 0; m_total = 64'd0;
            end
         end
         step(v, d, r, c);
         checks++; if (out_valid !== m_hold || out_valid_b !== m_hold) begin
            errors++; $display("FAIL rnd_valid[%0d]: got %b/%b want %b", i, out_valid, out_valid_b, m_hold);
         end
         checks++; if (in_ready !== !m_hold) begin errors++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", i, in_ready, !m_hold); end
         checks++; if (busy !== (m_n != 0)) begin errors++; $display("FAIL rnd_busy[%0d]: got %b want %b", i, busy, (m_n != 0)); end
         if (m_hold) begin
            checks++; if (out_sum !== e18[17:0] || ovf !== o18) begin
               errors++; $display("FAIL rnd_sum18[%0d]: got %h/%b want %h/%b", i, out_sum, ovf, e18[17:0], o18);
            end
            checks++; if (out_sum_b !== e17[16:0] || ovf_b !== o17) begin
               errors++; $display("FAIL rnd_sum17[%0d]: got %h/%b want %h/%b", i, out_sum_b, ovf_b, e17[16:0], o17);
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_d = 16'h0000; out_ready = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_bubbles();
      test_overflow();
      test_abort();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
